// File: rtl/m_seq_pkg.sv
// Shared types and constants for the m-sequence burst controller.
package m_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Feedback taps of x^31 + x^28 + 1
  localparam int TAP_HI = 30;
  localparam int TAP_LO = 27;

  localparam logic [30:0] DEFAULT_SEED = 31'h7FFFFFFF;

  // An all-zero seed would lock the LFSR, so it is replaced by the default.
  function automatic logic [30:0] fix_seed(input logic [30:0] s);
    return (s == '0) ? DEFAULT_SEED : s;
  endfunction

endpackage

// File: rtl/m_seq_lfsr.sv
// 31-bit Fibonacci LFSR (x^31 + x^28 + 1) with synchronous load and step.
module m_seq_lfsr
  import m_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [30:0] seed,
  input  logic        step,
  output logic [30:0] state
);

  logic [30:0] state_q;
  logic [30:0] state_d;

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = seed;
    end else if (step) begin
      state_d = {state_q[29:0], state_q[TAP_HI] ^ state_q[TAP_LO]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DEFAULT_SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/m_seq_ctrl.sv
// Burst controller emitting bit_count m-sequence bits with a divided sclk.
// Optional byte decode of the emitted bits is enabled by M_SEQ_DATA_DECODE_EN.
module m_seq_ctrl
  import m_seq_pkg::*;
#(
  parameter int DIV_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             CLK_50MHZ,
  input  logic             RST,
  input  logic             start,
  input  logic             stop,
  input  logic [30:0]      seed,
  input  logic [CNT_W-1:0] bit_count,
  input  logic [DIV_W-1:0] div,
  output logic             sclk,
  output logic             out_fun,
  output logic [30:0]      buff_wr,
  output logic [7:0]       data,
  output logic             data_valid,
  output logic             busy,
  output logic             done
);

  localparam logic [DIV_W:0]   PH_ONE  = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_t           state_q, state_d;
  logic [DIV_W:0]   ph_q, ph_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             sclk_q, sclk_d;
  logic             lfsr_load;
  logic             lfsr_step;
  logic [DIV_W:0]   ph_last;
  logic [DIV_W:0]   ph_rise;

  // A bit period spans phases 0 .. 2*div+1; sclk rises after phase div.
  assign ph_last = {div_q, 1'b1};
  assign ph_rise = {1'b0, div_q};

  always_comb begin
    state_d   = state_q;
    ph_d      = ph_q;
    rem_d     = rem_q;
    div_d     = div_q;
    sclk_d    = 1'b0;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_d   = S_LOAD;
          div_d     = div;
          rem_d     = bit_count;
          lfsr_load = 1'b1;
        end
      end
      S_LOAD: begin
        ph_d = '0;
        if (stop) begin
          state_d = S_IDLE;
        end else if (rem_q == '0) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
          ph_d    = '0;
        end else if (ph_q == ph_last) begin
          lfsr_step = 1'b1;
          ph_d      = '0;
          rem_d     = rem_q - CNT_ONE;
          if (rem_q == CNT_ONE) begin
            state_d = S_DONE;
          end
        end else begin
          ph_d   = ph_q + PH_ONE;
          sclk_d = (ph_q == ph_rise) ? 1'b1 : sclk_q;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK_50MHZ or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      ph_q    <= '0;
      rem_q   <= '0;
      div_q   <= '0;
      sclk_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      sclk_q  <= sclk_d;
    end
  end

  m_seq_lfsr u_lfsr (
    .clk   (CLK_50MHZ),
    .rst   (RST),
    .load  (lfsr_load),
    .seed  (fix_seed(seed)),
    .step  (lfsr_step),
    .state (buff_wr)
  );

  assign out_fun = buff_wr[TAP_HI];
  assign sclk    = sclk_q;
  assign busy    = (state_q == S_LOAD) || (state_q == S_RUN);
  // An abort arriving while in DONE suppresses the completion pulse.
  assign done    = (state_q == S_DONE) && !stop;

`ifdef M_SEQ_DATA_DECODE_EN
  logic [6:0] sh_q, sh_d;
  logic [2:0] bph_q, bph_d;
  logic [7:0] data_q, data_d;
  logic       dv_q, dv_d;

  always_comb begin
    sh_d   = sh_q;
    bph_d  = bph_q;
    data_d = data_q;
    dv_d   = 1'b0;
    if (state_q == S_LOAD) begin
      bph_d = '0;
    end else if (lfsr_step) begin
      sh_d  = {sh_q[5:0], out_fun};
      bph_d = bph_q + 3'd1;
      if (bph_q == 3'd7) begin
        data_d = {sh_q, out_fun};
        dv_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK_50MHZ or posedge RST) begin
    if (RST) begin
      sh_q   <= '0;
      bph_q  <= '0;
      data_q <= '0;
      dv_q   <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      bph_q  <= bph_d;
      data_q <= data_d;
      dv_q   <= dv_d;
    end
  end

  assign data       = data_q;
  assign data_valid = dv_q;
`else
  assign data       = 8'h00;
  assign data_valid = 1'b0;
`endif

endmodule

// File: tb/tb_m_seq_ctrl.sv
// Self-checking bench for m_seq_ctrl: directed and random bursts against a timeline model.
module tb_m_seq_ctrl;

  logic        CLK_50MHZ = 1'b0;
  logic        RST       = 1'b1;
  logic        start     = 1'b0;
  logic        stop      = 1'b0;
  logic [30:0] seed      = '0;
  logic [15:0] bit_count = '0;
  logic [7:0]  div       = '0;
  logic        sclk, out_fun, data_valid, busy, done;
  logic [30:0] buff_wr;
  logic [7:0]  data;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [7:0]  exp_data = 8'h00;
  logic [30:0] cur_w    = 31'h7FFFFFFF;

`ifdef M_SEQ_DATA_DECODE_EN
  localparam bit DEC = 1'b1;
`else
  localparam bit DEC = 1'b0;
`endif

  m_seq_ctrl #(.DIV_W(8), .CNT_W(16)) dut (
    .CLK_50MHZ  (CLK_50MHZ),
    .RST        (RST),
    .start      (start),
    .stop       (stop),
    .seed       (seed),
    .bit_count  (bit_count),
    .div        (div),
    .sclk       (sclk),
    .out_fun    (out_fun),
    .buff_wr    (buff_wr),
    .data       (data),
    .data_valid (data_valid),
    .busy       (busy),
    .done       (done)
  );

  always #10 CLK_50MHZ = ~CLK_50MHZ;

  function automatic logic [30:0] step_ref(input logic [30:0] x);
    return {x[29:0], x[30] ^ x[27]};
  endfunction

  function automatic logic [43:0] observed();
    return {busy, done, sclk, out_fun, data_valid, data, buff_wr};
  endfunction

  function automatic logic [43:0] expect_vec(input logic b, input logic d, input logic s,
                                             input logic v, input logic [30:0] w);
    return {b, d, s, w[30], v, exp_data, w};
  endfunction

  task automatic chk(input string tag, input logic [43:0] obs, input logic [43:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: {busy,done,sclk,out_fun,dv,data,buff_wr} observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag, input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge CLK_50MHZ);
      chk($sformatf("%s c%0d", tag, i), observed(), expect_vec(1'b0, 1'b0, 1'b0, 1'b0, cur_w));
    end
  endtask

  // Expected timeline after start is sampled: cycle 1 is LOAD, RUN begins at
  // cycle 2, each bit lasts 2*(div+1) cycles, DONE sits at 2 + cnt*period.
  task automatic run_burst(input int id, input logic [30:0] s, input int cnt, input int dv,
                           input int stop_k, input int restart_k);
    logic [30:0] sq[$];
    logic [30:0] x, ew, hold;
    int          per, done_k, last_k, n, a;
    logic        eb, ed, es, ev;
    x = (s == 31'd0) ? 31'h7FFFFFFF : s;
    sq.push_back(x);
    for (int i = 0; i < cnt; i++) begin
      x = step_ref(x);
      sq.push_back(x);
    end
    per    = 2 * (dv + 1);
    done_k = 2 + cnt * per;
    last_k = (stop_k > 0) ? stop_k + 2 : done_k + 1;
    hold   = sq[0];
    @(negedge CLK_50MHZ);
    seed      = s;
    bit_count = 16'(cnt);
    div       = 8'(dv);
    start     = 1'b1;
    stop      = 1'b0;
    for (int k = 1; k <= last_k; k++) begin
      @(negedge CLK_50MHZ);
      if (k == 1) begin
        seed      = $urandom;
        bit_count = 16'($urandom);
        div       = 8'($urandom);
      end
      eb = 1'b0; ed = 1'b0; es = 1'b0; ev = 1'b0;
      if (stop_k > 0 && k > stop_k) begin
        ew = hold;
      end else if (k == 1) begin
        eb = 1'b1;
        ew = sq[0];
      end else if (k <= done_k) begin
        n  = k - 2;
        a  = n / per;
        ew = sq[a];
        eb = (k < done_k);
        ed = (k == done_k);
        es = ((n % per) >= dv + 1);
        if (DEC && a > 0 && (a % 8) == 0 && (n % per) == 0) begin
          ev = 1'b1;
          for (int j = 0; j < 8; j++) exp_data[7-j] = sq[a-8+j][30];
        end
      end else begin
        ew = sq[cnt];
      end
      if (k == stop_k) hold = ew;
      chk($sformatf("burst%0d k%0d", id, k), observed(), expect_vec(eb, ed, es, ev, ew));
      stop  = (k == stop_k);
      start = (restart_k > 0 && k >= restart_k && k < restart_k + per);
    end
    start = 1'b0;
    stop  = 1'b0;
    cur_w = (stop_k > 0) ? hold : sq[cnt];
  endtask

  initial begin
    // Reset state, held and after release
    repeat (2) @(negedge CLK_50MHZ);
    chk("reset_held", observed(), expect_vec(1'b0, 1'b0, 1'b0, 1'b0, 31'h7FFFFFFF));
    RST = 1'b0;
    check_idle("after_reset", 2);

    run_burst(1, 31'h40000000, 2, 0, 0, 0);
    run_burst(2, 31'h00000000, 8, 0, 0, 0);
    run_burst(3, 31'h12345678, 0, 5, 0, 0);
    run_burst(4, 31'h2AAAAAAA, 4, 3, 0, 0);
    run_burst(5, 31'h0BADCAFE, 17, 0, 0, 0);

    // Abort during the second bit of a 10-bit burst, then a normal burst
    run_burst(6, 31'h55555555, 10, 1, 7, 0);
    check_idle("post_stop", 6);
    run_burst(7, 31'h01020304, 3, 1, 0, 0);

    // Abort while in LOAD
    run_burst(8, 31'h3000000F, 5, 0, 1, 0);
    check_idle("post_stop_load", 3);

    // start and stop together in IDLE are rejected
    @(negedge CLK_50MHZ);
    seed  = 31'h11111111;
    start = 1'b1;
    stop  = 1'b1;
    @(negedge CLK_50MHZ);
    start = 1'b0;
    stop  = 1'b0;
    chk("start_stop_idle", observed(), expect_vec(1'b0, 1'b0, 1'b0, 1'b0, cur_w));
    check_idle("start_stop_idle_after", 2);

    // Asynchronous reset mid-RUN
    @(negedge CLK_50MHZ);
    seed      = 31'h7654321;
    bit_count = 16'd10;
    div       = 8'd1;
    start     = 1'b1;
    @(negedge CLK_50MHZ);
    start = 1'b0;
    repeat (5) @(negedge CLK_50MHZ);
    #2 RST = 1'b1;
    #1;
    exp_data = 8'h00;
    cur_w    = 31'h7FFFFFFF;
    chk("rst_async", observed(), expect_vec(1'b0, 1'b0, 1'b0, 1'b0, 31'h7FFFFFFF));
    @(negedge CLK_50MHZ);
    RST = 1'b0;
    check_idle("post_rst", 45);

    // Re-asserted start during the second bit must not disturb the burst
    run_burst(9, 31'h6DB6DB6D, 5, 2, 0, 9);

    for (int r = 0; r < 8; r++) begin
      run_burst(10 + r, 31'($urandom), int'($urandom_range(1, 20)),
                int'($urandom_range(0, 3)), 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/m_seq_ctrl.md
M_SEQ_CTRL -- requirements
Module: m_seq_ctrl

Interface
REQ-001 The block SHALL have parameter DIV_W, default 8, meaning the width of the sclk divider setting.
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning the width of the burst length in bits.
REQ-003 The block SHALL have port CLK_50MHZ  input  1  sole clock, all logic on its rising edge.
REQ-004 The block SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port start  input  1  burst request, sampled only in IDLE.
REQ-006 The block SHALL have port stop  input  1  abort request, honoured in any state.
REQ-007 The block SHALL have port seed  input  31  LFSR initial value, captured on an accepted start.
REQ-008 The block SHALL have port bit_count  input  CNT_W  number of sequence bits to emit, captured on an accepted start.
REQ-009 The block SHALL have port div  input  DIV_W  half-period of sclk minus one, captured on an accepted start.
REQ-010 The block SHALL have port sclk  output  1  generated bit clock.
REQ-011 The block SHALL have port out_fun  output  1  current m-sequence bit, equal to buff_wr[30].
REQ-012 The block SHALL have port buff_wr  output  31  LFSR state.
REQ-013 The block SHALL have port data  output  8  last decoded byte.
REQ-014 The block SHALL have ports data_valid, busy and done  output  1 each: byte strobe, burst in progress, and burst-complete pulse.

Function
REQ-015 The FSM SHALL have states IDLE, LOAD, RUN and DONE; busy SHALL be 1 in LOAD and RUN only.
REQ-016 IDLE->LOAD SHALL occur on start=1 and stop=0; start in any other state SHALL be ignored.
REQ-017 LOAD SHALL last one cycle and SHALL set buff_wr=seed, except that seed==0 SHALL load 31'h7FFFFFFF (lock-up avoidance).
REQ-018 LOAD->DONE SHALL occur if the captured bit_count==0, with no sclk activity; otherwise LOAD->RUN.
REQ-019 In RUN, the bit period SHALL be 2*(div+1) cycles: sclk low for the first div+1 cycles and high for the next div+1.
REQ-020 The first sclk rising edge SHALL occur div+1 cycles after RUN entry, i.e. start at cycle t gives sclk=1 at t+2+div+1.
REQ-021 On the last cycle of each bit period, the LFSR SHALL advance: buff_wr <= {buff_wr[29:0], buff_wr[30]^buff_wr[27]}, which is the polynomial x^31+x^28+1.
REQ-022 As a result, out_fun SHALL be stable across every sclk rising edge.
REQ-023 After bit_count periods, RUN->DONE SHALL occur with sclk=0; the counter SHALL be CNT_W wide, so bit_count=2^CNT_W-1 SHALL NOT wrap.
REQ-024 DONE SHALL assert done for exactly one cycle and then return to IDLE.
REQ-025 stop=1 in LOAD, RUN or DONE SHALL force IDLE next cycle with sclk=0 and no done pulse; buff_wr SHALL hold its value.
REQ-026 stop and start asserted together in IDLE SHALL leave the FSM in IDLE.

Reset
REQ-027 RST=1 SHALL asynchronously force state=IDLE, sclk=0, buff_wr=31'h7FFFFFFF, data=0, data_valid=0, busy=0, done=0, and clear all counters.
REQ-028 RST asserted mid-burst SHALL discard the burst, and no done pulse SHALL follow.

Configuration
REQ-029 With M_SEQ_DATA_DECODE_EN defined, each LFSR advance SHALL shift out_fun MSB-first into an 8-bit register.
REQ-030 With M_SEQ_DATA_DECODE_EN defined, every 8th shift of a burst SHALL load data and pulse data_valid for one cycle; a partial byte at burst end or stop SHALL be discarded and the bit phase reset at LOAD.
REQ-031 Without M_SEQ_DATA_DECODE_EN, data SHALL be constant 0, data_valid constant 0, and no decode logic SHALL be present.

Structure
REQ-032 Package m_seq_pkg SHALL hold the FSM state typedef, the tap constants (30, 27), and the default seed 31'h7FFFFFFF.
REQ-033 The LFSR register and feedback SHALL be a sub-module m_seq_lfsr with ports load, seed, step and state.

Verification
REQ-034 seed=31'h40000000, div=0, bit_count=2 -> out_fun 1 at the first sclk rise; buff_wr=31'h00000001 and out_fun 0 at the second; one done pulse.
REQ-035 seed=0, bit_count=8, macro on -> buff_wr=31'h7FFFFFFF in LOAD; data=8'hFF with one data_valid pulse.
REQ-036 bit_count=0 -> sclk stays 0; done 2 cycles after start; busy high 1 cycle.
REQ-037 div=3, bit_count=4 -> sclk period 8 cycles, 4 rising edges, done after the 4th falling edge.
REQ-038 stop asserted during the 2nd bit of a 10-bit burst -> IDLE next cycle, no done; a following start runs normally.
REQ-039 RST pulsed mid-RUN -> all outputs at reset values in the same cycle; start re-asserted in the 2nd bit -> ignored.
